// File: rtl/gps_cfg_sequencer.sv
// GPS power-up configuration sequencer: streams ROM messages 0..2 to the UART
// over valid/ready and switches to the fast baud rate once message 0 has drained.
module gps_cfg_sequencer #(
    parameter int unsigned GAP_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [1:0] rom_message,
    output logic [5:0] rom_index,
    input  logic [7:0] rom_data,
    input  logic [5:0] rom_length,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       tx_idle,
    output logic       baud_fast,
    output logic       busy,
    output logic       done
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES) + 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DRAIN,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state, state_next;
    logic [1:0]       message_next;
    logic [5:0]       index_next;
    logic [7:0]       data_next;
    logic             baud_next;
    logic             done_next;
    logic [GAP_W-1:0] gap_cnt, gap_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rom_message <= '0;
            rom_index   <= '0;
            tx_data     <= '0;
            baud_fast   <= 1'b0;
            done        <= 1'b0;
            gap_cnt     <= '0;
        end else begin
            state       <= state_next;
            rom_message <= message_next;
            rom_index   <= index_next;
            tx_data     <= data_next;
            baud_fast   <= baud_next;
            done        <= done_next;
            gap_cnt     <= gap_next;
        end
    end

    always_comb begin
        state_next   = state;
        message_next = rom_message;
        index_next   = rom_index;
        data_next    = tx_data;
        baud_next    = baud_fast;
        done_next    = done;
        gap_next     = gap_cnt;
        tx_valid     = (state == S_SEND);
        busy         = (state == S_LOAD) || (state == S_SEND) ||
                       (state == S_DRAIN) || (state == S_GAP);

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    message_next = '0;
                    index_next   = '0;
                    baud_next    = 1'b0;
                    done_next    = 1'b0;
                    state_next   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (rom_length == '0) begin
                    state_next = S_DRAIN;
                end else begin
                    data_next  = rom_data;
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    if (rom_index == rom_length - 6'd1) begin
                        state_next = S_DRAIN;
                    end else begin
                        index_next = rom_index + 6'd1;
                        state_next = S_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                // Baud switch waits for the shift register to empty, not just the last accept
                if (tx_idle) begin
                    if (rom_message == 2'd0) begin
                        baud_next = 1'b1;
                    end
                    gap_next   = GAP_LOAD;
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    if (rom_message == 2'd2) begin
                        done_next  = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        message_next = rom_message + 2'd1;
                        index_next   = '0;
                        state_next   = S_LOAD;
                    end
                end else begin
                    gap_next = gap_cnt - GAP_ONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gps_cfg_sequencer.sv
// Scoreboard bench for gps_cfg_sequencer: behavioural ROM, expected byte queue,
// one task per scenario.
module tb_gps_cfg_sequencer;

    localparam int unsigned GAP = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] rom_message;
    logic [5:0] rom_index;
    logic [7:0] rom_data;
    logic [5:0] rom_length;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_idle;
    logic       baud_fast;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rom_mem [4][64];
    int unsigned rom_len_tbl [4];
    logic        zero1;
    logic [7:0]  exp_q [$];

    int          r_bytes, r_baud_at, r_baud_cyc, r_m1_cyc, r_done_cyc;
    int          r_last_cyc, r_first_valid, r_idle_rise;
    logic [63:0] r_first8;
    logic [15:0] r_last2;

    always #5 clk = ~clk;

    gps_cfg_sequencer #(.GAP_CYCLES(GAP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .rom_message(rom_message),
        .rom_index(rom_index),
        .rom_data(rom_data),
        .rom_length(rom_length),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_idle(tx_idle),
        .baud_fast(baud_fast),
        .busy(busy),
        .done(done)
    );

    always_comb begin
        rom_length = 6'(rom_len_tbl[rom_message]);
        if (zero1 && rom_message == 2'd1) rom_length = '0;
        rom_data = '0;
        if (rom_index < rom_length) rom_data = rom_mem[rom_message][rom_index];
    end

    task automatic load_msg(input int m, input string s);
        for (int i = 0; i < s.len(); i++) rom_mem[m][i] = s[i];
        rom_mem[m][s.len()]     = 8'h0D;
        rom_mem[m][s.len() + 1] = 8'h0A;
        rom_len_tbl[m] = s.len() + 2;
    endtask

    task automatic push_expected(input bit z1);
        for (int m = 0; m < 3; m++) begin
            if (!(z1 && m == 1)) begin
                for (int i = 0; i < int'(rom_len_tbl[m]); i++) exp_q.push_back(rom_mem[m][i]);
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Drives tx_ready/tx_idle/start each cycle and retires accepted bytes against exp_q.
    task automatic run_stream(input int ready_pct, input int hold, input bit restart_mid);
        int         cyc = 0;
        int         hold_cnt = 0;
        bit         seen_done = 0;
        bit         prev_stall = 0;
        logic [7:0] prev_data = '0;
        logic [7:0] e;
        r_bytes = 0; r_baud_at = -1; r_baud_cyc = 0; r_m1_cyc = 0; r_done_cyc = 0;
        r_last_cyc = 0; r_first_valid = 0; r_idle_rise = 0; r_first8 = '0; r_last2 = '0;
        while (!seen_done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            tx_ready = ($urandom_range(99) < ready_pct);
            if (hold != 0 && r_bytes == 20 && hold_cnt < hold) begin
                tx_idle = 1'b0;
                hold_cnt++;
            end else begin
                if (tx_idle == 1'b0) r_idle_rise = cyc;
                tx_idle = 1'b1;
            end
            start = restart_mid && (cyc == 30);
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                             tx_valid, tx_data, prev_data);
                end
            end
            if (tx_valid && r_first_valid == 0) r_first_valid = cyc;
            if (baud_fast && r_baud_cyc == 0) begin
                r_baud_cyc = cyc;
                r_baud_at  = r_bytes;
            end
            if (tx_valid && r_bytes == 20 && r_m1_cyc == 0) r_m1_cyc = cyc;
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_byte: got %h expected no byte", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL byte_%0d: got %h expected %h", r_bytes, tx_data, e);
                    end
                end
                if (r_bytes < 8) r_first8 = {r_first8[55:0], tx_data};
                r_last2 = {r_last2[7:0], tx_data};
                r_bytes++;
                r_last_cyc = cyc;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (done) begin
                seen_done  = 1;
                r_done_cyc = cyc;
            end
        end
        start = 1'b0; tx_ready = 1'b1; tx_idle = 1'b1;
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL done_timeout: got done=0 after %0d cycles expected done=1", cyc);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_bytes: got %0d unsent expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({tx_data, tx_valid, rom_message, rom_index, baud_fast, busy, done} !== 20'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {tx_data, tx_valid, rom_message, rom_index, baud_fast, busy, done});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_full_run();
        push_expected(1'b0);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_latency_busy: got busy=%b valid=%b expected 1 0", busy, tx_valid);
        end
        run_stream(100, 0, 1'b0);
        checks++;
        if (r_first_valid != 1) begin
            errors++;
            $display("FAIL first_valid_cycle: got %0d expected 1", r_first_valid);
        end
        checks++;
        if (r_bytes != 88) begin
            errors++;
            $display("FAIL full_count: got %0d expected 88", r_bytes);
        end
        checks++;
        if (r_first8 !== 64'h24504D544B323531) begin
            errors++;
            $display("FAIL full_prefix: got %h expected 24504d544b323531", r_first8);
        end
        checks++;
        if (r_last2 !== 16'h0D0A) begin
            errors++;
            $display("FAIL full_suffix: got %h expected 0d0a", r_last2);
        end
        checks++;
        if (r_baud_at != 20) begin
            errors++;
            $display("FAIL baud_position: got %0d expected 20", r_baud_at);
        end
        checks++;
        if (r_m1_cyc - r_baud_cyc != int'(GAP) + 1) begin
            errors++;
            $display("FAIL baud_to_msg1: got %0d expected %0d", r_m1_cyc - r_baud_cyc, GAP + 1);
        end
        checks++;
        if (r_done_cyc - r_last_cyc != int'(GAP) + 2) begin
            errors++;
            $display("FAIL done_latency: got %0d expected %0d", r_done_cyc - r_last_cyc, GAP + 2);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || baud_fast !== 1'b1) begin
            errors++;
            $display("FAIL done_state: got busy=%b done=%b baud=%b expected 0 1 1", busy, done, baud_fast);
        end
    endtask

    task automatic test_start_in_done();
        push_expected(1'b0);
        pulse_start();
        checks++;
        if (done !== 1'b0 || baud_fast !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clears: got done=%b baud=%b busy=%b expected 0 0 1", done, baud_fast, busy);
        end
        run_stream(100, 0, 1'b0);
        checks++;
        if (r_bytes != 88 || r_first8 !== 64'h24504D544B323531) begin
            errors++;
            $display("FAIL restart_stream: got %0d bytes prefix %h expected 88 24504d544b323531", r_bytes, r_first8);
        end
    endtask

    task automatic test_start_while_busy();
        push_expected(1'b0);
        pulse_start();
        run_stream(100, 0, 1'b1);
        checks++;
        if (r_bytes != 88) begin
            errors++;
            $display("FAIL busy_start_count: got %0d expected 88", r_bytes);
        end
    endtask

    task automatic test_backpressure();
        push_expected(1'b0);
        pulse_start();
        run_stream(30, 0, 1'b0);
        checks++;
        if (r_bytes != 88 || r_baud_at != 20) begin
            errors++;
            $display("FAIL bp_stream: got %0d bytes baud_at %0d expected 88 20", r_bytes, r_baud_at);
        end
    endtask

    task automatic test_drain_hold();
        push_expected(1'b0);
        pulse_start();
        run_stream(100, 50, 1'b0);
        checks++;
        if (r_idle_rise == 0 || r_baud_cyc != r_idle_rise + 1) begin
            errors++;
            $display("FAIL drain_baud: got baud cycle %0d expected %0d", r_baud_cyc, r_idle_rise + 1);
        end
        checks++;
        if (r_m1_cyc - r_baud_cyc != int'(GAP) + 1 || r_baud_at != 20) begin
            errors++;
            $display("FAIL drain_msg1: got gap %0d baud_at %0d expected %0d 20",
                     r_m1_cyc - r_baud_cyc, r_baud_at, GAP + 1);
        end
    endtask

    task automatic test_reset_mid_send();
        tx_ready = 1'b1;
        pulse_start();
        repeat (7) @(posedge clk);
        #1 tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || rom_index == 6'd0) begin
            errors++;
            $display("FAIL mid_send_setup: got valid=%b index=%0d expected 1 nonzero", tx_valid, rom_index);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_data, tx_valid, rom_message, rom_index, baud_fast, busy, done} !== 20'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0",
                     {tx_data, tx_valid, rom_message, rom_index, baud_fast, busy, done});
        end
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || rom_message !== 2'd0 || rom_index !== 6'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b valid=%b msg=%0d idx=%0d expected 0 0 0 0",
                     busy, tx_valid, rom_message, rom_index);
        end
    endtask

    task automatic test_zero_length();
        zero1 = 1'b1;
        push_expected(1'b1);
        pulse_start();
        run_stream(100, 0, 1'b0);
        checks++;
        if (r_bytes != 37 || r_baud_at != 20 || r_last2 !== 16'h0D0A) begin
            errors++;
            $display("FAIL zero_length: got %0d bytes baud_at %0d tail %h expected 37 20 0d0a",
                     r_bytes, r_baud_at, r_last2);
        end
        zero1 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; tx_ready = 1'b1; tx_idle = 1'b1; zero1 = 1'b0;
        for (int m = 0; m < 4; m++) begin
            rom_len_tbl[m] = 0;
            for (int i = 0; i < 64; i++) rom_mem[m][i] = 8'h00;
        end
        load_msg(0, "$PMTK251,115200*1F");
        load_msg(1, "$PMTK314,0,1,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0*28");
        load_msg(2, "$PMTK220,200*2C");
        test_reset();
        test_full_run();
        test_start_in_done();
        test_start_while_busy();
        test_backpressure();
        test_drain_hold();
        test_reset_mid_send();
        test_zero_length();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
